// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single memory port between the CPU bus and a DMA requester
//   (boot loader / serial block). One access at a time is sequenced through
//   IDLE -> ACCESS -> ACK -> IDLE, holding the memory strobes for
//   WAIT_STATES+1 cycles. o_cpu_stall freezes the CPU T-state counter while
//   the CPU waits for memory.
//
//   Latency: a request seen in IDLE at cycle 0 is acknowledged at cycle
//   WAIT_STATES+2. Back-to-back accesses take WAIT_STATES+3 cycles each.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, the CPU wins every tie (the DMA can starve)
//   defined   : a 1-bit pointer names the requester that wins the next tie.
//               It is set to the non-winner after each grant and reset to CPU.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_reset      synchronous active-high reset
//   i_cpu_req    CPU request, held until o_cpu_ack
//   i_cpu_we     CPU write enable (1 = write)
//   i_cpu_addr   CPU address
//   i_cpu_wdata  CPU write data
//   o_cpu_rdata  CPU read data, valid with o_cpu_ack, held until the next CPU read
//   o_cpu_ack    one-cycle pulse when the CPU access completes
//   o_cpu_stall  i_cpu_req & ~o_cpu_ack (combinational)
//   i_dma_req    DMA request, held until o_dma_ack
//   i_dma_we     DMA write enable
//   i_dma_addr   DMA address
//   i_dma_wdata  DMA write data
//   o_dma_rdata  DMA read data, valid with o_dma_ack
//   o_dma_ack    one-cycle pulse when the DMA access completes
//   o_mem_en     memory access strobe
//   o_mem_we     memory write strobe
//   o_mem_addr   memory address
//   o_mem_wdata  memory write data
//   i_mem_rdata  memory read data, sampled on the last ACCESS cycle
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_stall,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  // Wait-state count fits in 4 bits (0..15).
  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  state_t            r_state;
  logic [3:0]        r_wait_cnt;
  logic              r_grant_dma;   // 1: current access belongs to the DMA
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_cpu_ack;
  logic              r_dma_ack;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              r_rr_ptr;      // 0: CPU wins the next tie, 1: DMA wins
`endif

  logic              w_any_req;
  logic              w_grant_dma;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Arbitration: decide which requester wins if an access starts this cycle.
  always_comb begin
    w_any_req = i_cpu_req | i_dma_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_cpu_req && i_dma_req) begin
      w_grant_dma = r_rr_ptr;
    end else begin
      w_grant_dma = i_dma_req;
    end
`else
    w_grant_dma = i_dma_req & ~i_cpu_req;
`endif
  end

  // Request mux: select the winner's address, write enable and write data.
  always_comb begin
    if (w_grant_dma) begin
      w_sel_we    = i_dma_we;
      w_sel_addr  = i_dma_addr;
      w_sel_wdata = i_dma_wdata;
    end else begin
      w_sel_we    = i_cpu_we;
      w_sel_addr  = i_cpu_addr;
      w_sel_wdata = i_cpu_wdata;
    end
  end

  // Access sequencer: state, wait counter, memory strobes, read capture, acks.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 4'd0;
      r_grant_dma <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_cpu_rdata <= {DATA_W{1'b0}};
      r_dma_rdata <= {DATA_W{1'b0}};
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_rr_ptr    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cpu_ack <= 1'b0;
          r_dma_ack <= 1'b0;
          if (w_any_req) begin
            // Latch the winner so later input changes cannot disturb the access.
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_we    <= w_sel_we;
            r_mem_en    <= 1'b1;
            r_wait_cnt  <= LP_WAIT;
            r_grant_dma <= w_grant_dma;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_ptr    <= ~w_grant_dma;
`endif
            r_state     <= ST_ACCESS;
          end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          if (r_wait_cnt == 4'd0) begin
            // Last access cycle: memory data is valid now.
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_grant_dma) begin
              r_dma_ack <= 1'b1;
              if (!r_mem_we) begin
                r_dma_rdata <= i_mem_rdata;
              end
            end else begin
              r_cpu_ack <= 1'b1;
              if (!r_mem_we) begin
                r_cpu_rdata <= i_mem_rdata;
              end
            end
            r_state <= ST_ACK;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
            r_state    <= ST_ACCESS;
          end
        end

        ST_ACK: begin
          r_cpu_ack <= 1'b0;
          r_dma_ack <= 1'b0;
          r_mem_en  <= 1'b0;
          r_mem_we  <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_cpu_ack <= 1'b0;
          r_dma_ack <= 1'b0;
          r_mem_en  <= 1'b0;
          r_mem_we  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_dma_rdata = r_dma_rdata;
  assign o_dma_ack   = r_dma_ack;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  // Stall is combinational so the T-state counter releases in the ack cycle.
  assign o_cpu_stall = i_cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Instance "a" uses WAIT_STATES=1, instance
//   "b" uses WAIT_STATES=3; both share the requester inputs and mem_rdata and
//   have separate resets. Inputs are driven and outputs sampled on the falling
//   edge. Cycle k below means the k-th falling edge after the rising edge that
//   granted the access (cycle 0 is the IDLE cycle in which the request is seen).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset_a;
  logic        reset_b;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata;
  logic        a_cpu_ack, a_cpu_stall, a_dma_ack, a_mem_en, a_mem_we;
  logic [15:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata;
  logic        b_cpu_ack, b_cpu_stall, b_dma_ack, b_mem_en, b_mem_we;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) u_dut_a (
    .i_clk(clk), .i_reset(reset_a),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(a_cpu_rdata), .o_cpu_ack(a_cpu_ack), .o_cpu_stall(a_cpu_stall),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(a_dma_rdata), .o_dma_ack(a_dma_ack),
    .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
    .o_mem_wdata(a_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(3)) u_dut_b (
    .i_clk(clk), .i_reset(reset_b),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(b_cpu_rdata), .o_cpu_ack(b_cpu_ack), .o_cpu_stall(b_cpu_stall),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(b_dma_rdata), .o_dma_ack(b_dma_ack),
    .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
    .o_mem_wdata(b_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Main directed sequence.
  initial begin
    logic [1:0] exp_acks;

    // ---- 1: reset with requests asserted --------------------------------
    reset_a = 1'b1; reset_b = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1111; cpu_wdata = 16'h2222;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h3333; dma_wdata = 16'h4444;
    mem_rdata = 16'hFFFF;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_val("rst_mem_en",    32'(a_mem_en),    32'h0);
    check_val("rst_mem_we",    32'(a_mem_we),    32'h0);
    check_val("rst_mem_addr",  32'(a_mem_addr),  32'h0);
    check_val("rst_mem_wdata", 32'(a_mem_wdata), 32'h0);
    check_val("rst_cpu_ack",   32'(a_cpu_ack),   32'h0);
    check_val("rst_dma_ack",   32'(a_dma_ack),   32'h0);
    check_val("rst_cpu_rdata", 32'(a_cpu_rdata), 32'h0);
    check_val("rst_dma_rdata", 32'(a_dma_rdata), 32'h0);
    check_val("rst_b_mem_en",  32'(b_mem_en),    32'h0);
    cpu_req = 1'b0; dma_req = 1'b0; reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);
    check_val("idle_mem_en",   32'(a_mem_en),    32'h0);
    check_val("idle_stall",    32'(a_cpu_stall), 32'h0);

    // ---- 2: CPU read of 0x0100, W=1 -------------------------------------
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; mem_rdata = 16'h1234;
    @(negedge clk); // cycle 1
    check_val("rd_c1_mem_en",   32'(a_mem_en),    32'h1);
    check_val("rd_c1_mem_we",   32'(a_mem_we),    32'h0);
    check_val("rd_c1_mem_addr", 32'(a_mem_addr),  32'h0100);
    check_val("rd_c1_stall",    32'(a_cpu_stall), 32'h1);
    check_val("rd_c1_ack",      32'(a_cpu_ack),   32'h0);
    @(negedge clk); // cycle 2
    check_val("rd_c2_mem_en",   32'(a_mem_en),    32'h1);
    check_val("rd_c2_ack",      32'(a_cpu_ack),   32'h0);
    @(negedge clk); // cycle 3
    check_val("rd_c3_ack",      32'(a_cpu_ack),   32'h1);
    check_val("rd_c3_rdata",    32'(a_cpu_rdata), 32'h1234);
    check_val("rd_c3_stall",    32'(a_cpu_stall), 32'h0);
    check_val("rd_c3_mem_en",   32'(a_mem_en),    32'h0);
    check_val("rd_c3_dma_ack",  32'(a_dma_ack),   32'h0);
    cpu_req = 1'b0; mem_rdata = 16'h0BAD;
    @(negedge clk); // cycle 4
    check_val("rd_c4_ack",      32'(a_cpu_ack),   32'h0);
    check_val("rd_c4_rdata",    32'(a_cpu_rdata), 32'h1234);

    // ---- 3: DMA write 0xBEEF to 0x8000, W=1 -----------------------------
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8000; dma_wdata = 16'hBEEF;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check_val($sformatf("wr_c%0d_mem_en", k),    32'(a_mem_en),    32'h1);
      check_val($sformatf("wr_c%0d_mem_we", k),    32'(a_mem_we),    32'h1);
      check_val($sformatf("wr_c%0d_mem_addr", k),  32'(a_mem_addr),  32'h8000);
      check_val($sformatf("wr_c%0d_mem_wdata", k), 32'(a_mem_wdata), 32'hBEEF);
      check_val($sformatf("wr_c%0d_dma_ack", k),   32'(a_dma_ack),   32'h0);
      // Inputs changing mid-access must not disturb the latched request.
      dma_addr = 16'h0F0F; dma_wdata = 16'h1357;
    end
    @(negedge clk); // cycle 3
    check_val("wr_c3_dma_ack",   32'(a_dma_ack),   32'h1);
    check_val("wr_c3_mem_en",    32'(a_mem_en),    32'h0);
    check_val("wr_c3_mem_we",    32'(a_mem_we),    32'h0);
    check_val("wr_c3_cpu_rdata", 32'(a_cpu_rdata), 32'h1234);
    check_val("wr_c3_dma_rdata", 32'(a_dma_rdata), 32'h0);
    dma_req = 1'b0;
    @(negedge clk); // cycle 4
    check_val("wr_c4_dma_ack",   32'(a_dma_ack),   32'h0);

    // ---- 4/5: both requests held (fixed priority or round robin) ---------
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020;
    mem_rdata = 16'h7777;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      case (k)
        3, 11:   exp_acks = 2'b10;
        7, 15:   exp_acks = RR ? 2'b01 : 2'b10;
        19:      exp_acks = 2'b01;
        default: exp_acks = 2'b00;
      endcase
      check_val($sformatf("tie_c%0d_acks{cpu,dma}", k), 32'({a_cpu_ack, a_dma_ack}), 32'(exp_acks));
      if (k == 16) cpu_req = 1'b0;
      if (k == 19) dma_req = 1'b0;
    end
    check_val("tie_dma_rdata", 32'(a_dma_rdata), 32'h7777);

    // ---- 6: reset in the 2nd ACCESS cycle, W=3 (instance b) -------------
    reset_b = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200; mem_rdata = 16'hC0DE;
    @(negedge clk); // cycle 1
    check_val("ra_c1_mem_en",   32'(b_mem_en),   32'h1);
    check_val("ra_c1_mem_addr", 32'(b_mem_addr), 32'h0200);
    @(negedge clk); // cycle 2
    check_val("ra_c2_mem_en",   32'(b_mem_en),   32'h1);
    reset_b = 1'b1; cpu_req = 1'b0;
    @(negedge clk); // cycle 3: reset applied
    check_val("ra_c3_mem_en",   32'(b_mem_en),   32'h0);
    check_val("ra_c3_mem_addr", 32'(b_mem_addr), 32'h0);
    check_val("ra_c3_cpu_ack",  32'(b_cpu_ack),  32'h0);
    reset_b = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      @(negedge clk);
      check_val($sformatf("ra_c%0d_no_ack", k), 32'({b_cpu_ack, b_dma_ack, b_mem_en}), 32'h0);
    end
    // Fresh DMA read completes normally: mem_en cycles 1-4, ack cycle 5.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300; mem_rdata = 16'h5A5A;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check_val($sformatf("fr_c%0d_mem_en", k),  32'(b_mem_en),  32'((k >= 1 && k <= 4) ? 1 : 0));
      check_val($sformatf("fr_c%0d_dma_ack", k), 32'(b_dma_ack), 32'((k == 5) ? 1 : 0));
      if (k == 5) begin
        check_val("fr_dma_rdata", 32'(b_dma_rdata), 32'h5A5A);
        dma_req = 1'b0;
      end
    end
    check_val("fr_cpu_rdata", 32'(b_cpu_rdata), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
